oled_text_arbiter: RTL and testbench
====================================

// Module: oled_text_arbiter
// PURPOSE
//  Shares the single oledControl character port (sendData/sendDataValid/sendDone) between two
//  text requesters. Each requester streams a message byte by byte. A message is granted whole,
//  so its bytes are never interleaved with the other requester's. Grants alternate round-robin.
//  A watchdog aborts a message if oledControl stalls. Sits between app-level text sources and oledControl.
// PARAMETERS
//  TIMEOUT_CYC  default 2_000_000  max cycles in SEND awaiting sendDone; 0 disables watchdog
//  TW           default 21         width of watchdog counter (must hold TIMEOUT_CYC)
// PORTS
//  clock          in   1  100MHz system clock
//  reset          in   1  asynchronous, active-high reset
//  req0_valid     in   1  requester 0 has a byte; held high for whole message
//  req0_data      in   8  requester 0 ASCII byte; stable while req0_valid and not req0_ready
//  req0_last      in   1  current byte is last of message
//  req0_ready     out  1  1-cycle pulse: byte consumed (sent or flushed)
//  req1_valid/req1_data/req1_last/req1_ready  same as req0 for requester 1
//  sendData       out  8  byte to oledControl
//  sendDataValid  out  1  request to oledControl
//  sendDone       in   1  oledControl byte-complete level
//  grant          out  2  one-hot owner of port; 00 when idle
//  busy           out  1  high in any state except IDLE
//  msg_done       out  1  1-cycle pulse when last byte of a message is sent
//  timeout_err    out  1  sticky watchdog flag
//  err_clear      in   1  clears timeout_err (lower priority than a same-cycle new timeout)
// BEHAVIOUR
//  Reset: state=IDLE, sendData=0, sendDataValid=0, grant=00, all readys/msg_done=0, timeout_err=0,
//   priority pointer=req0, watchdog=0. Asserting reset mid-message drops sendDataValid at once.
//  FSM (all outputs registered):
//   IDLE:     if any valid -> pick priority req if valid, else the other; set grant; -> WAIT_LOW.
//   WAIT_LOW: wait for sendDone==0 AND granted valid==1; then sendData<=data, sendDataValid<=1,
//             watchdog<=0; -> SEND. Granted valid low here = stall (grant kept, no timeout).
//   SEND:     if sendDone: sendDataValid<=0, ready of grantee pulses 1 cycle;
//               if last: msg_done pulse, pointer<=other req, grant<=00 -> IDLE; else -> WAIT_LOW.
//             else if TIMEOUT_CYC!=0 and watchdog==TIMEOUT_CYC-1: sendDataValid<=0,
//               timeout_err<=1, ready pulses (byte discarded); if last -> IDLE (pointer flips),
//               else -> FLUSH. Otherwise watchdog++.
//   FLUSH:    each cycle grantee valid==1: ready pulses (byte discarded, 1 byte/2 cycles:
//             ready then gap); on last consumed: pointer flips, grant<=00 -> IDLE. No msg_done.
//  Byte latency: sendDataValid rises 1 cycle after WAIT_LOW condition met; falls the cycle after
//   sendDone is sampled high; next byte never issued until sendDone seen low again.
//  Both requesters valid in IDLE: pointer wins; the other waits for the full message to finish.
//  Only one requester valid: it is granted regardless of pointer (no idle bubbles beyond 1 cycle).
//  New request while busy: ignored until return to IDLE; never preempts.
//  ready never pulses for a non-granted requester; ready and msg_done coincide on last byte.
//  Watchdog counts only in SEND; wraps never (saturates at compare point).
// TESTING
//  1. req0 sends "Hi"(0x48,0x69,last); model sendDone 5 cycles after valid -> sendData 0x48 then 0x69,
//     two req0_ready pulses, one msg_done, grant 01 then 00.
//  2. req0 and req1 valid same cycle after reset -> req0 message fully sent first, then req1;
//     repeat -> req1 first (round-robin).
//  3. req1 raises valid mid-req0 3-byte message -> no req1 byte until req0 last sent; grant never 11.
//  4. TIMEOUT_CYC=16, sendDone stuck 0 on byte 1 of 3 -> valid drops at 16 cycles, timeout_err=1,
//     remaining 2 bytes flushed via ready, no msg_done; err_clear -> timeout_err=0.
//  5. sendDone held high at grant -> sendDataValid stays 0 until sendDone falls.
//  6. Assert reset during SEND -> sendDataValid, grant, busy 0 asynchronously; clean resend after.

Source files
------------

// File: rtl/oled_text_arbiter.sv
// Two-requester, message-atomic, round-robin arbiter in front of the oledControl
// character port, with a stall watchdog that aborts and flushes a stuck message.
module oled_text_arbiter #(
   parameter int TIMEOUT_CYC = 2_000_000,
   parameter int TW          = 21
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   input  logic       req1_last,
   output logic       req1_ready,
   output logic [7:0] sendData,
   output logic       sendDataValid,
   input  logic       sendDone,
   output logic [1:0] grant,
   output logic       busy,
   output logic       msg_done,
   output logic       timeout_err,
   input  logic       err_clear
);

   typedef enum logic [1:0] {IDLE, WAIT_LOW, SEND, FLUSH} state_t;

   localparam logic          WD_ON   = (TIMEOUT_CYC != 0);
   localparam logic [TW-1:0] WD_LAST = (TIMEOUT_CYC == 0) ? '0 : TW'(TIMEOUT_CYC - 1);

   state_t        state_reg;
   logic          ptr_reg;
   logic [1:0]    grant_reg;
   logic [7:0]    send_data_reg;
   logic          send_valid_reg;
   logic [1:0]    ready_reg;
   logic          msg_done_reg;
   logic          timeout_err_reg;
   logic          busy_reg;
   logic          last_reg;
   logic [TW-1:0] wd_reg;

   // Granted requester's stream, selected by the one-hot grant.
   logic       g_valid;
   logic [7:0] g_data;
   logic       g_last;
   logic       g_ready;

   always_comb begin
      g_valid = grant_reg[1] ? req1_valid : req0_valid;
      g_data  = grant_reg[1] ? req1_data  : req0_data;
      g_last  = grant_reg[1] ? req1_last  : req0_last;
      g_ready = grant_reg[1] ? ready_reg[1] : ready_reg[0];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg       <= IDLE;
         ptr_reg         <= 1'b0;
         grant_reg       <= 2'b00;
         send_data_reg   <= 8'h00;
         send_valid_reg  <= 1'b0;
         ready_reg       <= 2'b00;
         msg_done_reg    <= 1'b0;
         timeout_err_reg <= 1'b0;
         busy_reg        <= 1'b0;
         last_reg        <= 1'b0;
         wd_reg          <= '0;
      end else begin
         ready_reg    <= 2'b00;
         msg_done_reg <= 1'b0;
         // A timeout raised below in the same cycle overrides this clear.
         if (err_clear)
            timeout_err_reg <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (req0_valid || req1_valid) begin
                  if (ptr_reg ? req1_valid : !req0_valid)
                     grant_reg <= 2'b10;
                  else
                     grant_reg <= 2'b01;
                  busy_reg  <= 1'b1;
                  state_reg <= WAIT_LOW;
               end
            end

            WAIT_LOW: begin
               if (!sendDone && g_valid) begin
                  send_data_reg  <= g_data;
                  send_valid_reg <= 1'b1;
                  last_reg       <= g_last;
                  wd_reg         <= '0;
                  state_reg      <= SEND;
               end
            end

            SEND: begin
               if (sendDone) begin
                  send_valid_reg <= 1'b0;
                  ready_reg      <= grant_reg;
                  if (last_reg) begin
                     msg_done_reg <= 1'b1;
                     ptr_reg      <= !grant_reg[1];
                     grant_reg    <= 2'b00;
                     busy_reg     <= 1'b0;
                     state_reg    <= IDLE;
                  end else begin
                     state_reg <= WAIT_LOW;
                  end
               end else if (WD_ON && wd_reg == WD_LAST) begin
                  // Abort: the in-flight byte is discarded and the rest flushed.
                  send_valid_reg  <= 1'b0;
                  timeout_err_reg <= 1'b1;
                  ready_reg       <= grant_reg;
                  if (last_reg) begin
                     ptr_reg   <= !grant_reg[1];
                     grant_reg <= 2'b00;
                     busy_reg  <= 1'b0;
                     state_reg <= IDLE;
                  end else begin
                     state_reg <= FLUSH;
                  end
               end else if (wd_reg != '1) begin
                  wd_reg <= wd_reg + 1'b1;
               end
            end

            FLUSH: begin
               // The cycle after a ready pulse is skipped so the requester can advance.
               if (g_valid && !g_ready) begin
                  ready_reg <= grant_reg;
                  if (g_last) begin
                     ptr_reg   <= !grant_reg[1];
                     grant_reg <= 2'b00;
                     busy_reg  <= 1'b0;
                     state_reg <= IDLE;
                  end
               end
            end

            default: state_reg <= IDLE;
         endcase
      end
   end

   assign req0_ready    = ready_reg[0];
   assign req1_ready    = ready_reg[1];
   assign sendData      = send_data_reg;
   assign sendDataValid = send_valid_reg;
   assign grant         = grant_reg;
   assign busy          = busy_reg;
   assign msg_done      = msg_done_reg;
   assign timeout_err   = timeout_err_reg;

endmodule

// File: tb/tb_oled_text_arbiter.sv
// Directed bench for oled_text_arbiter: two streaming requesters and an oledControl
// responder that raises sendDone 5 cycles after sendDataValid (or stalls on command).
module tb_oled_text_arbiter;

   localparam int TO = 16;

   logic       clock = 1'b0;
   logic       reset;
   logic       req0_valid, req0_last, req0_ready;
   logic [7:0] req0_data;
   logic       req1_valid, req1_last, req1_ready;
   logic [7:0] req1_data;
   logic [7:0] sendData;
   logic       sendDataValid;
   logic       sendDone;
   logic [1:0] grant;
   logic       busy;
   logic       msg_done;
   logic       timeout_err;
   logic       err_clear;

   always #5 clock = ~clock;

   oled_text_arbiter #(.TIMEOUT_CYC(TO), .TW(21)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
      .sendData(sendData), .sendDataValid(sendDataValid), .sendDone(sendDone),
      .grant(grant), .busy(busy), .msg_done(msg_done),
      .timeout_err(timeout_err), .err_clear(err_clear)
   );

   // Written by the stimulus block only.
   logic [7:0] msg0[$];
   logic [7:0] msg1[$];
   int         seq0 = 0, seq1 = 0;
   logic       stuck = 1'b0, force_high = 1'b0;

   // Written by the responder/monitor block only.
   int         seen0 = 0, seen1 = 0, idx0 = 0, idx1 = 0, cnt = 0;
   logic [8:0] sent_log[$];
   int         ready0_cnt = 0, ready1_cnt = 0, msg_done_cnt = 0, sdv_cycles = 0;
   logic       grant_bad = 1'b0;

   int tests = 0, fails = 0;

   always @(negedge clock) begin
      if (seq0 != seen0) begin seen0 = seq0; idx0 = 0; end
      if (seq1 != seen1) begin seen1 = seq1; idx1 = 0; end
      if (reset) begin
         sendDone = 1'b0;
         cnt      = 0;
      end else begin
         if (sendDataValid) sdv_cycles++;
         if (grant == 2'b11) grant_bad = 1'b1;
         if (msg_done) msg_done_cnt++;
         if (force_high) begin
            sendDone = 1'b1;
         end else if (stuck) begin
            sendDone = 1'b0;
         end else if (sendDataValid) begin
            cnt++;
            if (cnt >= 5 && !sendDone) begin
               sendDone = 1'b1;
               sent_log.push_back({grant[1], sendData});
               $display("[TB] sent byte 0x%02h from req%0d", sendData, grant[1]);
            end
         end else begin
            cnt      = 0;
            sendDone = 1'b0;
         end
         if (req0_ready) begin ready0_cnt++; idx0++; end
         if (req1_ready) begin ready1_cnt++; idx1++; end
      end
      req0_valid = (idx0 < msg0.size());
      req0_data  = req0_valid ? msg0[idx0] : 8'h00;
      req0_last  = req0_valid && (idx0 == msg0.size() - 1);
      req1_valid = (idx1 < msg1.size());
      req1_data  = req1_valid ? msg1[idx1] : 8'h00;
      req1_last  = req1_valid && (idx1 == msg1.size() - 1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k;
      k = 0;
      tick(2);
      while ((busy || req0_valid || req1_valid) && k < budget) begin
         tick(1);
         k++;
      end
      chk({tag, "_in_budget"}, 32'(k < budget), 32'd1);
   endtask

   function automatic logic [8:0] log_at(input int i);
      return (i < sent_log.size()) ? sent_log[i] : 9'h1FF;
   endfunction

   int base, r0, r1, md;

   initial begin
      reset     = 1'b1;
      err_clear = 1'b0;
      tick(3);
      chk("rst_sdv",   32'(sendDataValid), 32'd0);
      chk("rst_data",  32'(sendData), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
      chk("rst_err",   32'(timeout_err), 32'd0);
      chk("rst_done",  32'(msg_done), 32'd0);
      reset = 1'b0;
      tick(2);

      // 1: req0 sends "Hi"
      base = sent_log.size(); r0 = ready0_cnt; md = msg_done_cnt;
      msg0 = '{8'h48, 8'h69}; seq0++;
      tick(2);
      chk("t1_grant_busy", 32'(grant), 32'd1);
      wait_done("t1", 200);
      chk("t1_nbytes", 32'(sent_log.size() - base), 32'd2);
      chk("t1_b0", 32'(log_at(base)), 32'h048);
      chk("t1_b1", 32'(log_at(base + 1)), 32'h069);
      chk("t1_ready0", 32'(ready0_cnt - r0), 32'd2);
      chk("t1_msg_done", 32'(msg_done_cnt - md), 32'd1);
      chk("t1_grant_idle", 32'(grant), 32'd0);

      // 2a: simultaneous requests straight after reset -> req0 message first
      reset = 1'b1; tick(1); reset = 1'b0; tick(1);
      base = sent_log.size();
      msg0 = '{8'h41, 8'h42}; seq0++;
      msg1 = '{8'h61, 8'h62}; seq1++;
      wait_done("t2a", 400);
      chk("t2a_b0", 32'(log_at(base)), 32'h041);
      chk("t2a_b1", 32'(log_at(base + 1)), 32'h042);
      chk("t2a_b2", 32'(log_at(base + 2)), 32'h161);
      chk("t2a_b3", 32'(log_at(base + 3)), 32'h162);

      // 2b: after a lone req0 message the pointer favours req1
      msg0 = '{8'h51}; seq0++;
      wait_done("t2b_solo", 200);
      base = sent_log.size();
      msg0 = '{8'h52}; seq0++;
      msg1 = '{8'h63}; seq1++;
      wait_done("t2b", 400);
      chk("t2b_first",  32'(log_at(base)), 32'h163);
      chk("t2b_second", 32'(log_at(base + 1)), 32'h052);

      // 3: req1 arrives mid-message and must wait
      base = sent_log.size(); r1 = ready1_cnt;
      msg0 = '{8'h31, 8'h32, 8'h33}; seq0++;
      tick(8);
      chk("t3_grant_req0", 32'(grant), 32'd1);
      msg1 = '{8'h71}; seq1++;
      wait_done("t3", 400);
      chk("t3_b0", 32'(log_at(base)), 32'h031);
      chk("t3_b1", 32'(log_at(base + 1)), 32'h032);
      chk("t3_b2", 32'(log_at(base + 2)), 32'h033);
      chk("t3_b3", 32'(log_at(base + 3)), 32'h171);
      chk("t3_ready1", 32'(ready1_cnt - r1), 32'd1);
      chk("t3_grant_never_11", 32'(grant_bad), 32'd0);

      // 4: watchdog abort and flush
      base = sent_log.size(); r0 = ready0_cnt; md = msg_done_cnt;
      stuck = 1'b1;
      tick(1);
      r1 = sdv_cycles;
      msg0 = '{8'h41, 8'h42, 8'h43}; seq0++;
      wait_done("t4", 200);
      chk("t4_sdv_cycles", 32'(sdv_cycles - r1), 32'd16);
      chk("t4_timeout_err", 32'(timeout_err), 32'd1);
      chk("t4_ready0", 32'(ready0_cnt - r0), 32'd3);
      chk("t4_no_msg_done", 32'(msg_done_cnt - md), 32'd0);
      chk("t4_none_sent", 32'(sent_log.size() - base), 32'd0);
      stuck = 1'b0;
      tick(2);
      chk("t4_err_sticky", 32'(timeout_err), 32'd1);
      err_clear = 1'b1; tick(1); err_clear = 1'b0;
      chk("t4_err_cleared", 32'(timeout_err), 32'd0);

      // 5: sendDone already high at grant holds off the byte
      force_high = 1'b1;
      tick(2);
      base = sent_log.size(); md = msg_done_cnt;
      msg0 = '{8'h55}; seq0++;
      tick(10);
      chk("t5_sdv_held", 32'(sendDataValid), 32'd0);
      chk("t5_grant", 32'(grant), 32'd1);
      chk("t5_busy", 32'(busy), 32'd1);
      force_high = 1'b0;
      wait_done("t5", 200);
      chk("t5_b0", 32'(log_at(base)), 32'h055);
      chk("t5_msg_done", 32'(msg_done_cnt - md), 32'd1);

      // 6: asynchronous reset during SEND, then a clean resend
      msg0 = '{8'h77, 8'h78}; seq0++;
      r1 = 0;
      tick(2);
      while (!sendDataValid && r1 < 50) begin tick(1); r1++; end
      chk("t6_reached_send", 32'(sendDataValid), 32'd1);
      tick(2);
      reset = 1'b1;
      #1;
      chk("t6_rst_sdv", 32'(sendDataValid), 32'd0);
      chk("t6_rst_grant", 32'(grant), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      msg0 = '{}; seq0++;
      tick(2);
      reset = 1'b0;
      tick(2);
      base = sent_log.size(); md = msg_done_cnt;
      msg0 = '{8'h77, 8'h78}; seq0++;
      wait_done("t6", 200);
      chk("t6_nbytes", 32'(sent_log.size() - base), 32'd2);
      chk("t6_b0", 32'(log_at(base)), 32'h077);
      chk("t6_b1", 32'(log_at(base + 1)), 32'h078);
      chk("t6_msg_done", 32'(msg_done_cnt - md), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
